// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch/decode/execute sequencer driving the program counter.
// Each instruction is latched in FETCH, held stable in DECODE, and acted on
// in EXEC, where one PC strobe (increment or load) is issued for one cycle.
// Optional call/return stack enabled by defining PC_CTRL_RETSTACK_EN.
module pc_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [7:0]        instr,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              zero_flag,
  output logic              incPC,
  output logic              loadPC,
  output logic [7:0]        PCinput,
  output logic [7:0]        ir,
  output logic              halted,
  output logic              stack_err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

  state_t     state, state_nxt;
  logic [3:0] opc;

  assign opc = ir[7:4];

`ifdef PC_CTRL_RETSTACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [3:0]       stk [STACK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic [3:0]       ret_addr;
  logic             stk_full;
  logic             stk_empty;

  assign top_idx   = IDX_W'(sp - 1'b1);
  assign push_idx  = IDX_W'(sp);
  assign ret_addr  = pc_cur[3:0] + 4'd1;
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
`else
  // No stack storage in this build; keep the otherwise-idle inputs visible.
  localparam int UNUSED_DEPTH = STACK_DEPTH;
  logic unused_pc;
  assign unused_pc = ^pc_cur;
  assign stack_err = 1'b0;
`endif

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Instruction register, loaded once per instruction in FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n)              ir <= 8'h00;
    else if (state == FETCH) ir <= instr;
  end

  // Next-state and single-cycle PC strobes decoded from state and ir.
  always_comb begin
    state_nxt = state;
    incPC     = 1'b0;
    loadPC    = 1'b0;
    PCinput   = 8'h00;
    halted    = 1'b0;
    case (state)
      IDLE:   if (run) state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        case (opc)
          4'hA: begin
            loadPC  = 1'b1;
            PCinput = {4'h0, ir[3:0]};
          end
          4'hB: begin
            if (zero_flag) begin
              loadPC  = 1'b1;
              PCinput = {4'h0, ir[3:0]};
            end else begin
              incPC = 1'b1;
            end
          end
          4'hF: state_nxt = HALT;
`ifdef PC_CTRL_RETSTACK_EN
          4'hC: begin
            // The jump is taken even when the push overflows.
            loadPC  = 1'b1;
            PCinput = {4'h0, ir[3:0]};
          end
          4'hD: begin
            if (stk_empty) begin
              incPC = 1'b1;
            end else begin
              loadPC  = 1'b1;
              PCinput = {4'h0, stk[top_idx]};
            end
          end
`endif
          default: incPC = 1'b1;
        endcase
      end
      HALT:    halted = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PC_CTRL_RETSTACK_EN
  // Stack pointer and sticky over/underflow flag, updated at the end of EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (state == EXEC) begin
      if (opc == 4'hC) begin
        if (stk_full) stack_err <= 1'b1;
        else          sp        <= sp + 1'b1;
      end else if (opc == 4'hD) begin
        if (stk_empty) stack_err <= 1'b1;
        else           sp        <= sp - 1'b1;
      end
    end
  end

  // Return-address storage; entries are only meaningful below sp.
  always_ff @(posedge clk) begin
    if (state == EXEC && opc == 4'hC && !stk_full) stk[push_idx] <= ret_addr;
  end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed testbench for pc_ctrl with hand-computed expectations.
module tb_pc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] instr;
  logic [3:0] pc_cur;
  logic       zero_flag;
  logic       incPC;
  logic       loadPC;
  logic [7:0] PCinput;
  logic [7:0] ir;
  logic       halted;
  logic       stack_err;

  int checks = 0;
  int errors = 0;

  pc_ctrl #(.ADDR_W(4), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .instr     (instr),
    .pc_cur    (pc_cur),
    .zero_flag (zero_flag),
    .incPC     (incPC),
    .loadPC    (loadPC),
    .PCinput   (PCinput),
    .ir        (ir),
    .halted    (halted),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: present run for one edge so the DUT enters FETCH.
  task automatic start();
    run = 1'b1;
    step();
    run = 1'b0;
    check("fetch_strobes", {30'd0, incPC, loadPC}, 32'd0);
  endtask

  // Called with the DUT in FETCH; leaves it in FETCH of the next instruction.
  task automatic exec_instr(input string tag, input logic [7:0] i, input logic zf,
                            input logic [3:0] pc, input logic ei, input logic el,
                            input logic [7:0] ep);
    instr     = i;
    zero_flag = zf;
    pc_cur    = pc;
    step();
    check({tag, "_ir"}, {24'd0, ir}, {24'd0, i});
    check({tag, "_decode_strobes"}, {30'd0, incPC, loadPC}, 32'd0);
    step();
    check({tag, "_incPC"}, {31'd0, incPC}, {31'd0, ei});
    check({tag, "_loadPC"}, {31'd0, loadPC}, {31'd0, el});
    check({tag, "_PCinput"}, {24'd0, PCinput}, {24'd0, ep});
    step();
    check({tag, "_after_strobes"}, {30'd0, incPC, loadPC}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    instr     = 8'h00;
    pc_cur    = 4'h0;
    zero_flag = 1'b0;

    // Reset and idle behaviour
    do_reset();
    check("rst_incPC", {31'd0, incPC}, 32'd0);
    check("rst_loadPC", {31'd0, loadPC}, 32'd0);
    check("rst_PCinput", {24'd0, PCinput}, 32'd0);
    check("rst_ir", {24'd0, ir}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_stack_err", {31'd0, stack_err}, 32'd0);
    instr = 8'hA5;
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_quiet", {24'd0, ir, 5'd0, incPC, loadPC, halted}, 32'd0);
    end

    // Basic instructions
    start();
    exec_instr("nop05", 8'h05, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00);
    exec_instr("jmpA9", 8'hA9, 1'b0, 4'h1, 1'b0, 1'b1, 8'h09);
    exec_instr("jzB3_z1", 8'hB3, 1'b1, 4'h9, 1'b0, 1'b1, 8'h03);
    exec_instr("jzB3_z0", 8'hB3, 1'b0, 4'h3, 1'b1, 1'b0, 8'h00);
    exec_instr("nop00", 8'h00, 1'b1, 4'h4, 1'b1, 1'b0, 8'h00);
    exec_instr("op7E", 8'h7E, 1'b0, 4'hF, 1'b1, 1'b0, 8'h00);
`ifndef PC_CTRL_RETSTACK_EN
    exec_instr("callC7_nop", 8'hC7, 1'b0, 4'hF, 1'b1, 1'b0, 8'h00);
    exec_instr("retD0_nop", 8'hD0, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00);
    check("nostack_err", {31'd0, stack_err}, 32'd0);
`endif

    // HALT: no strobes, run ignored, left only by reset
    instr = 8'hF0;
    step();
    check("halt_ir", {24'd0, ir}, 32'h0000_00F0);
    step();
    check("halt_exec_strobes", {30'd0, incPC, loadPC}, 32'd0);
    check("halt_exec_halted", {31'd0, halted}, 32'd0);
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("halt_hold", {29'd0, halted, incPC, loadPC}, 32'h4);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run   = 1'b0;
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    check("halt_rst_ir", {24'd0, ir}, 32'd0);
    step();
    check("post_halt_idle", {29'd0, halted, incPC, loadPC}, 32'd0);

    // Reset on the edge that would enter EXEC: no strobe at all
    start();
    instr = 8'hA9;
    step();
    rst_n = 1'b0;
    step();
    check("midrst_strobes", {30'd0, incPC, loadPC}, 32'd0);
    check("midrst_PCinput", {24'd0, PCinput}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("midrst_idle", {30'd0, incPC, loadPC}, 32'd0);

`ifdef PC_CTRL_RETSTACK_EN
    // Call / return through the stack
    start();
    exec_instr("callC7", 8'hC7, 1'b0, 4'hF, 1'b0, 1'b1, 8'h07);
    exec_instr("retD0", 8'hD0, 1'b0, 4'h7, 1'b0, 1'b1, 8'h00);
    exec_instr("call1", 8'hC1, 1'b0, 4'h8, 1'b0, 1'b1, 8'h01);
    exec_instr("call2", 8'hC2, 1'b0, 4'h1, 1'b0, 1'b1, 8'h02);
    exec_instr("call3", 8'hC3, 1'b0, 4'h5, 1'b0, 1'b1, 8'h03);
    exec_instr("call4", 8'hC4, 1'b0, 4'h2, 1'b0, 1'b1, 8'h04);
    check("full_no_err", {31'd0, stack_err}, 32'd0);
    exec_instr("call5", 8'hC5, 1'b0, 4'hA, 1'b0, 1'b1, 8'h05);
    check("overflow_err", {31'd0, stack_err}, 32'd1);
    exec_instr("ret_after_ovf", 8'hD0, 1'b0, 4'h5, 1'b0, 1'b1, 8'h03);
    check("err_sticky", {31'd0, stack_err}, 32'd1);
    do_reset();
    check("err_rst", {31'd0, stack_err}, 32'd0);
    start();
    exec_instr("ret_empty", 8'hD0, 1'b0, 4'h6, 1'b1, 1'b0, 8'h00);
    check("underflow_err", {31'd0, stack_err}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
